demux16_stream: RTL and testbench

//  1-to-16 stream demultiplexer: accepts one N-bit word per valid/ready handshake with a 4-bit

---
 rtl/demux_pkg.sv | 6 +
 rtl/decoder_4_16.sv | 12 +
 rtl/demux16_stream.sv | 63 ++++++
 tb/tb_demux16_stream.sv | 134 +++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select width and state encoding for the stream demux
package demux_pkg;
   localparam int NUM_CH = 16;
   localparam int SEL_W  = 4;
   typedef enum logic {EMPTY, FULL} demux_state_t;
endpackage

// File: rtl/decoder_4_16.sv
// decoder_4_16: gated one-hot decode of a 4-bit channel select
module decoder_4_16
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0]  sel,
   input  logic              en,
   output logic [NUM_CH-1:0] onehot
);
   logic [NUM_CH-1:0] one;
   assign one    = {{(NUM_CH-1){1'b0}}, 1'b1};
   assign onehot = en ? one << sel : '0;
endmodule

// File: rtl/demux16_stream.sv
// demux16_stream: 1-to-16 valid/ready stream demux with one held word, channel enables and drop count
module demux16_stream
   import demux_pkg::*;
#(
   parameter int N     = 1,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [N-1:0]      out_data,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [CNT_W-1:0]  drop_cnt,
   input  logic              drop_clr
);
   demux_state_t      state_q, state_d;
   logic [SEL_W-1:0]  held_sel;
   logic [NUM_CH-1:0] in_oh;
   logic              full, in_fire, accept, drop, out_fire;

   decoder_4_16 u_in_dec  (.sel(in_sel),   .en(1'b1), .onehot(in_oh));
   decoder_4_16 u_out_dec (.sel(held_sel), .en(full), .onehot(out_valid));

   assign full     = state_q == FULL;
   assign out_fire = full & out_ready[held_sel];
   assign in_ready = rst_n & (~full | out_ready[held_sel]);
   assign in_fire  = in_valid & in_ready;
   assign accept   = in_fire & |(in_oh & ch_en);
   assign drop     = in_fire & ~|(in_oh & ch_en);

   // Holding register fills on an enabled accept and drains on an output transfer
   always_comb begin
      state_d = state_q;
      state_d = accept ? FULL : out_fire ? EMPTY : state_q;
   end

   // State, held word and its destination channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         out_data <= '0;
         held_sel <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_data <= in_data;
            held_sel <= in_sel;
         end
      end
   end

   // Saturating drop counter; clear wins over a same-cycle drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= '0;
      else if (drop_clr) drop_cnt <= '0;
      else if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
   end
endmodule

// File: tb/tb_demux16_stream.sv
// tb_demux16_stream: directed self-checking bench for demux16_stream
module tb_demux16_stream;
   logic        clk = 0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic [3:0]  in_sel;
   logic        in_valid;
   logic [15:0] ch_en;
   logic [15:0] out_ready;
   logic        drop_clr;
   logic        ir, s_ir;
   logic [7:0]  od, s_od;
   logic [15:0] ov, s_ov;
   logic [7:0]  dc;
   logic [1:0]  s_dc;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   demux16_stream #(.N(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(ir), .ch_en(ch_en), .out_data(od), .out_valid(ov), .out_ready(out_ready),
      .drop_cnt(dc), .drop_clr(drop_clr));

   demux16_stream #(.N(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(s_ir), .ch_en(ch_en), .out_data(s_od), .out_valid(s_ov), .out_ready(out_ready),
      .drop_cnt(s_dc), .drop_clr(drop_clr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; in_data = 0; in_sel = 0; in_valid = 0;
      ch_en = 16'hFFFF; out_ready = 16'hFFFF; drop_clr = 0;
      #12;
      check("rst_in_ready", 32'(ir), 0);
      check("rst_out_valid", 32'(ov), 0);
      check("rst_drop_cnt", 32'(dc), 0);
      check("rst_out_data", 32'(od), 0);
      @(negedge clk); rst_n = 1; #1;
      check("empty_in_ready", 32'(ir), 1);
      tick();
      // single word
      in_valid = 1; in_sel = 5; in_data = 8'hA5;
      tick(); in_valid = 0;
      check("single_valid", 32'(ov), 32'h0020);
      check("single_data", 32'(od), 32'hA5);
      tick();
      check("single_drain", 32'(ov), 0);
      // back-to-back with channel switches
      in_valid = 1; in_sel = 0; in_data = 8'h10;
      tick();
      check("b2b_v0", 32'(ov), 32'h0001);
      check("b2b_rdy0", 32'(ir), 1);
      in_sel = 15; in_data = 8'h11;
      tick();
      check("b2b_v15", 32'(ov), 32'h8000);
      check("b2b_d15", 32'(od), 32'h11);
      check("b2b_rdy15", 32'(ir), 1);
      in_sel = 3; in_data = 8'h12;
      tick(); in_valid = 0;
      check("b2b_v3", 32'(ov), 32'h0008);
      check("b2b_d3", 32'(od), 32'h12);
      tick();
      check("b2b_drain", 32'(ov), 0);
      // backpressure on held channel only
      out_ready = 16'hFFFB;
      in_valid = 1; in_sel = 2; in_data = 8'h22;
      tick();
      in_sel = 7; in_data = 8'h33;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(ov), 32'h0004);
         check("bp_data", 32'(od), 32'h22);
         check("bp_in_ready", 32'(ir), 0);
         tick();
      end
      out_ready = 16'hFFFF; #1;
      check("bp_release_rdy", 32'(ir), 1);
      tick(); in_valid = 0;
      check("bp_next_valid", 32'(ov), 32'h0080);
      check("bp_next_data", 32'(od), 32'h33);
      tick();
      check("bp_drain", 32'(ov), 0);
      // drops to a disabled channel
      ch_en = 16'hFFF7; in_valid = 1; in_sel = 3; in_data = 8'h44;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop_no_valid", 32'(ov), 0);
      end
      check("drop_cnt3", 32'(dc), 3);
      check("drop_sat3", 32'(s_dc), 3);
      check("drop_data_kept", 32'(od), 32'h33);
      tick();
      check("drop_cnt4", 32'(dc), 4);
      check("drop_sat_hold", 32'(s_dc), 3);
      drop_clr = 1;
      tick(); drop_clr = 0;
      check("drop_clr_cnt", 32'(dc), 0);
      check("drop_clr_sat", 32'(s_dc), 0);
      tick(); in_valid = 0;
      check("drop_after_clr", 32'(dc), 1);
      // enable sampled only at accept, then async reset while full
      ch_en = 16'hFFFF; out_ready = 16'h0000;
      in_valid = 1; in_sel = 9; in_data = 8'h99;
      tick(); in_valid = 0; ch_en = 16'h0000;
      tick();
      check("held_after_disable", 32'(ov), 32'h0200);
      check("held_data", 32'(od), 32'h99);
      #2 rst_n = 0; #1;
      check("async_rst_valid", 32'(ov), 0);
      check("async_rst_ready", 32'(ir), 0);
      check("async_rst_cnt", 32'(dc), 0);
      @(negedge clk); rst_n = 1; out_ready = 16'hFFFF; ch_en = 16'hFFFF;
      tick();
      check("post_rst_valid", 32'(ov), 0);
      check("post_rst_data", 32'(od), 0);
      tick();
      check("post_rst_valid2", 32'(ov), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
